// File: rtl/mips_pkg.sv
// mips_pkg -- shared constants for the MIPS pipeline control slice.
//   CTRL_RUN / CTRL_MEM_WAIT / CTRL_HALT : hazard-controller state encoding
//   REG_ZERO                             : hard-wired zero register index
//   NOP_INSTR                            : encoding of the pipeline bubble (sll $0,$0,0)
package mips_pkg;

  localparam logic [1:0]  CTRL_RUN      = 2'd0;
  localparam logic [1:0]  CTRL_MEM_WAIT = 2'd1;
  localparam logic [1:0]  CTRL_HALT     = 2'd2;

  localparam logic [4:0]  REG_ZERO      = 5'd0;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

endpackage

// File: rtl/haz_loaduse_cmp.sv
// haz_loaduse_cmp -- combinational load-use hazard detector.
// Ports:
//   EX_memread, EX_wraddr[4:0]  : load currently in EX and its destination
//   ID_rs, ID_rt [4:0]          : source registers of the instruction in ID
//   ID_uses_rs, ID_uses_rt      : ID instruction actually reads rs / rt
//   load_use                    : ID needs the value the EX load has not yet produced
module haz_loaduse_cmp
  import mips_pkg::*;
(
  input  logic       EX_memread,
  input  logic [4:0] EX_wraddr,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_uses_rs,
  input  logic       ID_uses_rt,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = ID_uses_rs && (ID_rs == EX_wraddr);
  assign rt_hit = ID_uses_rt && (ID_rt == EX_wraddr);

  // $zero is never really written, so a load targeting it creates no dependency.
  assign load_use = EX_memread && (EX_wraddr != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- stall/flush controller for a 5-stage MIPS pipeline.
// Resolves, per cycle and in priority order, HALT > data-memory wait >
// taken branch in EX > load-use hazard. Stall/flush outputs are combinational
// from the current state and inputs; state, wait counter, timeout flag and
// performance counters are registered.
// Parameters:
//   MEM_TIMEOUT : maximum MEM_WAIT cycles before the controller halts
//   CNT_W       : performance counter width
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   ID_rs/ID_rt/ID_uses_rs/ID_uses_rt   : ID-stage operand info
//   EX_memread/EX_wraddr                : load in EX and its destination
//   EX_branch_taken                     : branch/jump resolved taken in EX
//   MEM_memread/MEM_memwrite/mem_ready  : data-memory access in MEM and completion
//   pc_stall, *_stall                   : hold PC / stage register
//   *_flush                             : load a bubble into stage register
//   ctrl_state, mem_timeout             : FSM state, sticky timeout flag
//   stall_cnt, redirect_cnt             : performance counters
// Build option: define HAZ_PERF_CNT_EN to implement the saturating performance
// counters; otherwise both counters read constant 0.
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             EX_memread,
  input  logic [4:0]       EX_wraddr,
  input  logic             EX_branch_taken,
  input  logic             MEM_memread,
  input  logic             MEM_memwrite,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             ID_EX_stall,
  output logic             EX_MEM_stall,
  output logic             MEM_WB_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_flush,
  output logic [1:0]       ctrl_state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic [1:0]        state;
  logic [1:0]        state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_d;
  logic              timeout_d;
  logic              mem_busy;
  logic              load_use;

  assign mem_busy = (MEM_memread || MEM_memwrite) && !mem_ready;

  haz_loaduse_cmp u_loaduse (
    .EX_memread (EX_memread),
    .EX_wraddr  (EX_wraddr),
    .ID_rs      (ID_rs),
    .ID_rt      (ID_rt),
    .ID_uses_rs (ID_uses_rs),
    .ID_uses_rt (ID_uses_rt),
    .load_use   (load_use)
  );

  // Same-cycle stall/flush decode. Outside HALT the decode does not depend on
  // RUN vs MEM_WAIT: while waiting, EX and ID are frozen, so a branch or
  // load-use they hold naturally takes effect in the cycle mem_ready arrives.
  always_comb begin
    pc_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    ID_EX_stall  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_stall = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    MEM_WB_flush = 1'b0;
    if (state == CTRL_HALT) begin
      pc_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_stall = 1'b1;
    end else if (mem_busy) begin
      // MEM is held; WB receives a bubble instead of repeating the access.
      pc_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_flush = 1'b1;
    end else if (EX_branch_taken) begin
      // Wrong-path instructions in IF and ID are squashed; any load-use
      // involving them is moot.
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
    end else if (load_use) begin
      pc_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_flush  = 1'b1;
    end
  end

  always_comb begin
    state_d   = state;
    wait_d    = wait_cnt;
    timeout_d = mem_timeout;
    case (state)
      CTRL_RUN: begin
        if (mem_busy) begin
          state_d = CTRL_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      CTRL_MEM_WAIT: begin
        if (!mem_busy) begin
          state_d = CTRL_RUN;
          wait_d  = '0;
        end else if (wait_cnt == WAIT_MAX) begin
          state_d   = CTRL_HALT;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      CTRL_HALT: begin
        state_d = CTRL_HALT;
      end
      default: begin
        state_d = CTRL_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CTRL_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      wait_cnt    <= wait_d;
      mem_timeout <= timeout_d;
    end
  end

  assign ctrl_state = state;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] redirect_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // IF_ID_flush is only ever raised by the taken-branch redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (pc_stall)    stall_cnt_q    <= sat_inc(stall_cnt_q);
      if (IF_ID_flush) redirect_cnt_q <= sat_inc(redirect_cnt_q);
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`else
  assign stall_cnt    = '0;
  assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl -- directed self-checking bench for pipe_hazard_ctrl.
// Runs with MEM_TIMEOUT=4 and CNT_W=4 so timeout and counter saturation are
// reachable in a few cycles. Counter expectations follow HAZ_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  // Control vector order: pc, IF_ID_s, ID_EX_s, EX_MEM_s, MEM_WB_s,
  //                       IF_ID_f, ID_EX_f, EX_MEM_f, MEM_WB_f
  localparam logic [8:0] C_NONE = 9'b0_0000_0000;
  localparam logic [8:0] C_LU   = 9'b1_1000_0100;
  localparam logic [8:0] C_BR   = 9'b0_0000_1100;
  localparam logic [8:0] C_MEM  = 9'b1_1110_0001;
  localparam logic [8:0] C_HALT = 9'b1_1111_0000;

  logic       clk;
  logic       rst_n;
  logic [4:0] ID_rs, ID_rt, EX_wraddr;
  logic       ID_uses_rs, ID_uses_rt, EX_memread, EX_branch_taken;
  logic       MEM_memread, MEM_memwrite, mem_ready;
  logic       pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall;
  logic       IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
  logic [1:0] ctrl_state;
  logic       mem_timeout;
  logic [3:0] stall_cnt, redirect_cnt;
  logic [8:0] ctl;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ID_rs           (ID_rs),
    .ID_rt           (ID_rt),
    .ID_uses_rs      (ID_uses_rs),
    .ID_uses_rt      (ID_uses_rt),
    .EX_memread      (EX_memread),
    .EX_wraddr       (EX_wraddr),
    .EX_branch_taken (EX_branch_taken),
    .MEM_memread     (MEM_memread),
    .MEM_memwrite    (MEM_memwrite),
    .mem_ready       (mem_ready),
    .pc_stall        (pc_stall),
    .IF_ID_stall     (IF_ID_stall),
    .ID_EX_stall     (ID_EX_stall),
    .EX_MEM_stall    (EX_MEM_stall),
    .MEM_WB_stall    (MEM_WB_stall),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_flush     (ID_EX_flush),
    .EX_MEM_flush    (EX_MEM_flush),
    .MEM_WB_flush    (MEM_WB_flush),
    .ctrl_state      (ctrl_state),
    .mem_timeout     (mem_timeout),
    .stall_cnt       (stall_cnt),
    .redirect_cnt    (redirect_cnt)
  );

  assign ctl = {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall,
                IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rs = 1'b0; ID_uses_rt = 1'b0;
    EX_memread = 1'b0; EX_wraddr = 5'd0; EX_branch_taken = 1'b0;
    MEM_memread = 1'b0; MEM_memwrite = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #1;
    // Reset state
    chk("rst_state",    32'(ctrl_state),   32'd0);
    chk("rst_timeout",  32'(mem_timeout),  32'd0);
    chk("rst_stallcnt", 32'(stall_cnt),    32'd0);
    chk("rst_redircnt", 32'(redirect_cnt), 32'd0);
    chk("rst_ctl",      32'(ctl),          32'(C_NONE));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Load-use on rs: one bubble, then clear
    EX_memread = 1'b1; EX_wraddr = 5'd8; ID_rs = 5'd8; ID_uses_rs = 1'b1;
    #1 chk("lu_rs", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_rs_stallcnt", 32'(stall_cnt), 32'(PERF * 1));
    clear_inputs();
    #1 chk("lu_after", 32'(ctl), 32'(C_NONE));
    chk("lu_state", 32'(ctrl_state), 32'd0);

    // Load-use on rt; then same register but rt not read
    EX_memread = 1'b1; EX_wraddr = 5'd8; ID_rs = 5'd3; ID_uses_rs = 1'b1;
    ID_rt = 5'd8; ID_uses_rt = 1'b1;
    #1 chk("lu_rt", 32'(ctl), 32'(C_LU));
    ID_uses_rt = 1'b0;
    #1 chk("lu_rt_unused", 32'(ctl), 32'(C_NONE));
    clear_inputs();

    // Load to $zero never stalls
    EX_memread = 1'b1; EX_wraddr = 5'd0; ID_rs = 5'd0; ID_uses_rs = 1'b1;
    #1 chk("lu_zero", 32'(ctl), 32'(C_NONE));
    tick();
    chk("lu_zero_stallcnt", 32'(stall_cnt), 32'(PERF * 1));

    // Branch beats load-use
    EX_memread = 1'b1; EX_wraddr = 5'd9; ID_rt = 5'd9; ID_uses_rt = 1'b1;
    EX_branch_taken = 1'b1;
    #1 chk("br_lu", 32'(ctl), 32'(C_BR));
    tick();
    chk("br_redircnt", 32'(redirect_cnt), 32'(PERF * 1));
    chk("br_stallcnt", 32'(stall_cnt),    32'(PERF * 1));
    clear_inputs();

    // Memory wait: ready low 3 cycles, then high
    MEM_memread = 1'b1;
    #1 chk("mw_c0_ctl", 32'(ctl), 32'(C_MEM));
    chk("mw_c0_state", 32'(ctrl_state), 32'd0);
    tick();
    chk("mw_c1_state", 32'(ctrl_state), 32'd1);
    chk("mw_c1_ctl",   32'(ctl),        32'(C_MEM));
    tick();
    chk("mw_c2_ctl",   32'(ctl),        32'(C_MEM));
    tick();
    chk("mw_c3_state", 32'(ctrl_state), 32'd1);
    mem_ready = 1'b1;
    #1 chk("mw_ready_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    chk("mw_done_state", 32'(ctrl_state), 32'd0);
    chk("mw_stallcnt",   32'(stall_cnt),  32'(PERF * 4));
    clear_inputs();

    // Branch and load-use held during a store wait act when ready arrives
    MEM_memwrite = 1'b1; EX_branch_taken = 1'b1;
    EX_memread = 1'b1; EX_wraddr = 5'd5; ID_rs = 5'd5; ID_uses_rs = 1'b1;
    #1 chk("mwbr_busy_ctl", 32'(ctl), 32'(C_MEM));
    tick();
    chk("mwbr_state", 32'(ctrl_state), 32'd1);
    mem_ready = 1'b1;
    #1 chk("mwbr_ready_ctl", 32'(ctl), 32'(C_BR));
    tick();
    chk("mwbr_done_state", 32'(ctrl_state),   32'd0);
    chk("mwbr_redircnt",   32'(redirect_cnt), 32'(PERF * 2));
    chk("mwbr_stallcnt",   32'(stall_cnt),    32'(PERF * 5));
    clear_inputs();

    // Timeout: ready never arrives
    MEM_memread = 1'b1;
    tick();                 // RUN -> MEM_WAIT, wait=1
    tick(); tick(); tick(); // wait 2,3,4
    chk("to_before_state",   32'(ctrl_state),  32'd1);
    chk("to_before_timeout", 32'(mem_timeout), 32'd0);
    tick();                 // wait==4 and busy -> HALT
    chk("to_state",   32'(ctrl_state),  32'd2);
    chk("to_timeout", 32'(mem_timeout), 32'd1);
    chk("to_ctl",     32'(ctl),         32'(C_HALT));
    chk("to_stallcnt", 32'(stall_cnt),  32'(PERF * 10));
    mem_ready = 1'b1; EX_branch_taken = 1'b1;
    #1 chk("halt_hold_ctl", 32'(ctl), 32'(C_HALT));
    tick();
    chk("halt_hold_state", 32'(ctrl_state), 32'd2);
    for (int i = 0; i < 10; i++) tick();
    chk("halt_stall_sat", 32'(stall_cnt),    32'(PERF * 15));
    chk("halt_redircnt",  32'(redirect_cnt), 32'(PERF * 2));

    // Asynchronous reset from HALT, away from any clock edge
    clear_inputs();
    MEM_memread = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_halt_state",   32'(ctrl_state),   32'd0);
    chk("arst_halt_timeout", 32'(mem_timeout),  32'd0);
    chk("arst_halt_cnt",     32'(stall_cnt),    32'd0);
    chk("arst_halt_ctl",     32'(ctl),          32'(C_MEM));
    tick();
    rst_n = 1'b1;

    // Asynchronous reset from MEM_WAIT
    tick();
    chk("arst_mw_pre", 32'(ctrl_state), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("arst_mw_state", 32'(ctrl_state), 32'd0);
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    chk("final_state", 32'(ctrl_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide parameters (name, default, meaning): MEM_TIMEOUT, 255, max MEM_WAIT cycles before HALT; CNT_W, 32, performance counter width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
REQ-005 ID_uses_rs, ID_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-006 EX_memread  in  1  EX holds a load; EX_wraddr  in  5  its destination register.
REQ-007 EX_branch_taken  in  1  branch/jump resolved taken in EX.
REQ-008 MEM_memread, MEM_memwrite  in  1 each  MEM holds a memory access; mem_ready  in  1  data memory completes this cycle.
REQ-009 pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall  out  1 each  hold the PC / stage register.
REQ-010 IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  load NOP into the stage register.
REQ-011 ctrl_state  out  2  FSM state (RUN=0, MEM_WAIT=1, HALT=2); mem_timeout  out  1  sticky timeout flag.
REQ-012 stall_cnt, redirect_cnt  out  CNT_W each  performance counters.

Function
REQ-013 Stall/flush outputs SHALL be combinational from current state and inputs (same-cycle effect); state, counters and flags SHALL be registered.
REQ-014 mem_busy = (MEM_memread|MEM_memwrite) & !mem_ready; load_use = EX_memread & EX_wraddr!=0 & ((ID_uses_rs & ID_rs==EX_wraddr) | (ID_uses_rt & ID_rt==EX_wraddr)).
REQ-015 Priority per cycle SHALL be HALT > mem_busy > EX_branch_taken > load_use.
REQ-016 RUN & mem_busy: assert pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_flush; next state MEM_WAIT; wait counter loads 1.
REQ-017 MEM_WAIT: same outputs as REQ-016 while mem_busy; wait counter increments each cycle; when mem_ready, all stalls deassert that cycle and next state RUN.
REQ-018 MEM_WAIT with wait counter == MEM_TIMEOUT and still busy: next state HALT, mem_timeout set.
REQ-019 HALT: pc_stall and all four stage stalls asserted, no flushes; exit only by reset.
REQ-020 RUN & EX_branch_taken (no mem_busy): assert IF_ID_flush and ID_EX_flush for exactly that cycle; load_use in the same cycle SHALL be ignored.
REQ-021 RUN & load_use only: assert pc_stall, IF_ID_stall, ID_EX_flush for one cycle (one bubble).
REQ-022 A branch or load-use present during MEM_WAIT SHALL take effect in the cycle mem_ready arrives, per REQ-015, since EX/ID are held.
REQ-023 Register 0 SHALL never cause a load-use stall.
REQ-024 Stall and flush of the same stage SHALL never both be asserted.

Reset
REQ-025 On rst_n low: state RUN, wait counter 0, mem_timeout 0, counters 0; outputs then follow REQ-013 from inputs.
REQ-026 Reset mid-MEM_WAIT or in HALT SHALL return to RUN immediately, asynchronously.

Configuration
REQ-027 Macro HAZ_PERF_CNT_EN defined: stall_cnt increments on every cycle pc_stall=1, redirect_cnt on every REQ-020 flush cycle; both saturate at all-ones.
REQ-028 Macro undefined: counter registers omitted, stall_cnt and redirect_cnt tied to 0; all other behaviour identical.

Structure
REQ-029 Shared package mips_pkg SHALL hold the ctrl_state encoding, REG_ZERO (5'd0) and the NOP instruction constant.
REQ-030 Load-use comparison SHALL be one combinational sub-module haz_loaduse_cmp; FSM and counters stay in pipe_hazard_ctrl.

Verification
REQ-031 EX_memread=1, EX_wraddr=8, ID_rs=8, ID_uses_rs=1 -> one cycle pc_stall=IF_ID_stall=ID_EX_flush=1, then all 0.
REQ-032 Same as REQ-031 with EX_wraddr=0 -> no stall, no flush.
REQ-033 EX_branch_taken=1 plus load_use -> IF_ID_flush=ID_EX_flush=1, pc_stall=0; redirect_cnt +1 with macro.
REQ-034 MEM_memread=1, mem_ready low 3 cycles then high -> stalls and MEM_WB_flush high 3 cycles, ctrl_state 1 then 0, stall_cnt=3 with macro.
REQ-035 MEM_TIMEOUT=4, mem_ready never high -> HALT after 4 MEM_WAIT cycles, mem_timeout=1, stalls held; rst_n pulse -> RUN, flag 0.
REQ-036 Build without HAZ_PERF_CNT_EN, rerun REQ-034 -> identical stall/flush waveforms, counters read 0.
